toggle_req_gen: RTL and testbench
=================================

TOGGLE_REQ_GEN -- requirements
Module: toggle_req_gen

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive synchronized samples required to accept a level change (legal range 2..15).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the debounce counter width, which must hold STABLE_CYCLES.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port BTN, input, 1 bit, raw asynchronous bouncing pushbutton level.
REQ-006 The block SHALL have port EN, input, 1 bit, synchronous enable for toggle pulse generation.
REQ-007 The block SHALL have port T, output, 1 bit, a single-cycle toggle request that drives the T input of the downstream T flip-flop.
REQ-008 The block SHALL have port STABLE, output, 1 bit, the debounced button level.
REQ-009 The block SHALL have port PRESS_CNT, output, 8 bits, the count of accepted presses that produced a T pulse.

Function
REQ-010 BTN SHALL pass through a 2-flop synchronizer; s denotes the second-stage output, and only s feeds the FSM.
REQ-011 The FSM SHALL have states IDLE (stable low), WAIT_HIGH, PRESSED (stable high) and WAIT_LOW.
REQ-012 In IDLE with s=1, the FSM SHALL go to WAIT_HIGH with cnt=1; with s=0 it SHALL stay in IDLE with cnt=0.
REQ-013 In WAIT_HIGH with s=0, the FSM SHALL return to IDLE with cnt=0 (bounce rejected, no output change).
REQ-014 In WAIT_HIGH with s=1 and cnt=STABLE_CYCLES-1, the FSM SHALL go to PRESSED, set STABLE=1 and reset cnt=0; otherwise it SHALL increment cnt.
REQ-015 PRESSED, WAIT_LOW and IDLE SHALL behave symmetrically to REQ-012..014 with levels inverted; acceptance in WAIT_LOW sets STABLE=0 and generates no T pulse.
REQ-016 T SHALL be registered and SHALL assert for exactly one CLK cycle on the same edge as the IDLE/WAIT_HIGH->PRESSED commit, but only if EN=1 at that edge.
REQ-017 PRESS_CNT SHALL increment by 1 on the same edge T asserts, and SHALL wrap from 255 to 0.
REQ-018 With EN=0 at the commit edge, STABLE SHALL still update, T SHALL stay 0 and PRESS_CNT SHALL hold; no pulse is deferred to later.
REQ-019 Latency SHALL be exactly STABLE_CYCLES+1 CLK edges from the first edge sampling BTN=1 to T=1, given BTN stays high.
REQ-020 A held button SHALL produce exactly one T pulse; a new pulse SHALL require a full accepted release followed by a full accepted press.
REQ-021 T SHALL never be high for two consecutive cycles.

Reset
REQ-022 RESET=1 SHALL immediately, independent of CLK, clear the synchronizer flops, set the FSM to IDLE, and set cnt=0, T=0, STABLE=0 and PRESS_CNT=0.
REQ-023 RESET asserted mid-count or mid-pulse SHALL abort without emitting or completing a T pulse.
REQ-024 After RESET deasserts with BTN already high, the block SHALL treat the level as a new press subject to full debounce.

Verification (STABLE_CYCLES=4)
REQ-025 Clean press: BTN 0->1 sampled at edge k, EN=1 -> T=1 only during the cycle after edge k+5, STABLE=1 from edge k+5, PRESS_CNT=1.
REQ-026 Bounce: BTN pattern 1,1,0,1,1,1,1 (per cycle) -> exactly one T pulse, issued after the final four consecutive highs clear the synchronizer.
REQ-027 Hold and release: BTN high for 20 cycles then low for 10 -> one T pulse, STABLE returns to 0 four synchronized samples after release, PRESS_CNT=1.
REQ-028 EN=0 press: EN=0 during the commit edge -> STABLE=1, T stays 0, PRESS_CNT unchanged.
REQ-029 Wrap: 256 clean presses -> PRESS_CNT=0, with 256 T pulses counted.
REQ-030 Reset mid-operation: RESET pulsed in WAIT_HIGH with cnt=2 -> all outputs 0 at once; with the T flip-flop attached, Q toggles once per accepted press only.

Source files
------------

// File: rtl/toggle_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : toggle_req_gen
// Purpose  : Debounces a raw pushbutton and issues a one-cycle T-flop toggle
//            request per accepted press, with a wrapping press counter.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_req_gen #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN,
  input  logic       EN,
  output logic       T,
  output logic       STABLE,
  output logic [7:0] PRESS_CNT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    PRESSED   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_t;
  logic             r_stable;
  logic [7:0]       r_press_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= BTN;
      r_sync2 <= r_sync1;
    end
  end

  // r_cnt counts consecutive synchronized samples that disagree with STABLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_cnt       <= c_cnt_zero;
      r_t         <= 1'b0;
      r_stable    <= 1'b0;
      r_press_cnt <= 8'd0;
    end else begin
      r_t <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sync2) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= c_cnt_one;
          end else begin
            r_cnt   <= c_cnt_zero;
          end
        end
        WAIT_HIGH: begin
          if (!r_sync2) begin
            r_state <= IDLE;
            r_cnt   <= c_cnt_zero;
          end else if (r_cnt == c_cnt_last) begin
            r_state  <= PRESSED;
            r_cnt    <= c_cnt_zero;
            r_stable <= 1'b1;
            // A press committed while disabled is dropped, never deferred.
            if (EN) begin
              r_t         <= 1'b1;
              r_press_cnt <= r_press_cnt + 8'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        PRESSED: begin
          if (!r_sync2) begin
            r_state <= WAIT_LOW;
            r_cnt   <= c_cnt_one;
          end else begin
            r_cnt   <= c_cnt_zero;
          end
        end
        WAIT_LOW: begin
          if (r_sync2) begin
            r_state <= PRESSED;
            r_cnt   <= c_cnt_zero;
          end else if (r_cnt == c_cnt_last) begin
            r_state  <= IDLE;
            r_cnt    <= c_cnt_zero;
            r_stable <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= c_cnt_zero;
        end
      endcase
    end
  end

  assign T         = r_t;
  assign STABLE    = r_stable;
  assign PRESS_CNT = r_press_cnt;

endmodule
`default_nettype wire

// File: tb/tb_toggle_req_gen.sv
`default_nettype none
// Testbench for toggle_req_gen: window-based debounce model checked every
// cycle, plus directed literal expectations for the key scenarios.
module tb_toggle_req_gen;

  localparam int N = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       BTN;
  logic       EN;
  logic       T;
  logic       STABLE;
  logic [7:0] PRESS_CNT;

  toggle_req_gen #(.STABLE_CYCLES(N), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BTN       (BTN),
    .EN        (EN),
    .T         (T),
    .STABLE    (STABLE),
    .PRESS_CNT (PRESS_CNT)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: s is BTN delayed two edges; the level flips once the last N
  // samples of s all disagree with it.
  logic       b1 = 1'b0, b2 = 1'b0, m_s, m_acc;
  logic       m_stable = 1'b0, m_t = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic       win[$];

  initial begin
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        b1 = 1'b0; b2 = 1'b0; win.delete();
        m_stable = 1'b0; m_t = 1'b0; m_cnt = 8'd0;
      end else begin
        m_s = b2; b2 = b1; b1 = BTN;
        win.push_back(m_s);
        if (win.size() > N) void'(win.pop_front());
        m_acc = (win.size() == N);
        foreach (win[i]) if (win[i] == m_stable) m_acc = 1'b0;
        m_t = 1'b0;
        if (m_acc) begin
          m_stable = ~m_stable;
          if (m_stable && EN) begin
            m_t   = 1'b1;
            m_cnt = m_cnt + 8'd1;
          end
        end
      end
    end
  end

  // Per-cycle compare, plus an attached T flip-flop that must track press parity.
  logic tq = 1'b0, prev_t = 1'b0;
  int   t_seen = 0;
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        tq = 1'b0; prev_t = 1'b0;
      end else begin
        chk("cyc_T",       int'(T),         int'(m_t));
        chk("cyc_STABLE",  int'(STABLE),    int'(m_stable));
        chk("cyc_PRESSCNT", int'(PRESS_CNT), int'(m_cnt));
        chk("cyc_tff_Q",   int'(tq),        int'(m_cnt[0] ^ m_t));
        chk("cyc_T_double", int'(prev_t & T), 0);
        if (T) begin
          tq = ~tq;
          t_seen++;
        end
        prev_t = T;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [6:0] tv, sv;
  logic [9:0] rv;
  int         t0, idx;
  logic       bpat [7];

  initial begin
    RESET = 1'b1; BTN = 1'b0; EN = 1'b1;
    cyc(2);
    chk("rst_T", int'(T), 0);
    chk("rst_STABLE", int'(STABLE), 0);
    chk("rst_PRESSCNT", int'(PRESS_CNT), 0);
    RESET = 1'b0;
    cyc(3);

    // Clean press: T after edge k+5 only, STABLE from k+5.
    BTN = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      tv[i] = T;
      sv[i] = STABLE;
    end
    chk("press_T_timing", int'(tv), int'(7'b0100000));
    chk("press_STABLE_timing", int'(sv), int'(7'b1100000));
    chk("press_PRESSCNT", int'(PRESS_CNT), 1);
    t0 = t_seen;
    cyc(13);
    chk("hold_no_pulse", t_seen - t0, 0);

    BTN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      rv[i] = STABLE;
    end
    chk("release_STABLE_timing", int'(rv), int'(10'b0000011111));
    chk("release_PRESSCNT", int'(PRESS_CNT), 1);

    // Bounce 1,1,0,1,1,1,1 then held: single pulse after edge k+8.
    bpat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t0 = t_seen; idx = -1;
    for (int i = 0; i < 15; i++) begin
      BTN = (i < 7) ? bpat[i] : 1'b1;
      cyc(1);
      if (T) idx = i;
    end
    chk("bounce_pulses", t_seen - t0, 1);
    chk("bounce_pulse_edge", idx, 8);
    chk("bounce_PRESSCNT", int'(PRESS_CNT), 2);
    BTN = 1'b0;
    cyc(8);

    // EN=0 at commit: level updates, no pulse now or later.
    EN = 1'b0; BTN = 1'b1; t0 = t_seen;
    cyc(8);
    chk("en0_STABLE", int'(STABLE), 1);
    chk("en0_PRESSCNT", int'(PRESS_CNT), 2);
    EN = 1'b1;
    cyc(4);
    chk("en0_no_deferred", t_seen - t0, 0);
    BTN = 1'b0;
    cyc(8);
    chk("en0_release_STABLE", int'(STABLE), 0);

    // Reset in WAIT_HIGH with cnt=2, then full debounce with BTN already high.
    BTN = 1'b1;
    cyc(4);
    RESET = 1'b1;
    #1;
    chk("midrst_T", int'(T), 0);
    chk("midrst_STABLE", int'(STABLE), 0);
    chk("midrst_PRESSCNT", int'(PRESS_CNT), 0);
    cyc(1);
    RESET = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      tv[i] = T;
    end
    chk("postrst_T_timing", int'(tv), int'(7'b0100000));
    chk("postrst_PRESSCNT", int'(PRESS_CNT), 1);
    BTN = 1'b0;
    cyc(8);

    // Reset while T is high aborts the pulse.
    BTN = 1'b1;
    cyc(6);
    chk("pulse_pre_T", int'(T), 1);
    RESET = 1'b1;
    #1;
    chk("pulse_rst_T", int'(T), 0);
    chk("pulse_rst_PRESSCNT", int'(PRESS_CNT), 0);
    cyc(1);
    RESET = 1'b0;
    cyc(8);
    BTN = 1'b0;
    cyc(8);

    // 256 clean presses from reset wrap the counter back to 0.
    RESET = 1'b1;
    cyc(1);
    RESET = 1'b0;
    cyc(2);
    t0 = t_seen;
    repeat (256) begin
      BTN = 1'b1;
      cyc(7);
      BTN = 1'b0;
      cyc(7);
    end
    chk("wrap_pulses", t_seen - t0, 256);
    chk("wrap_PRESSCNT", int'(PRESS_CNT), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
